gpr_file: RTL and testbench
===========================

GPR_FILE -- requirements
Module: gpr_file

Interface
REQ-001 Parameter GPR_NUM, default 32, number of general-purpose registers (2**GPRS_WIDTH).
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_sys_valid  input  1  write-back stage has a result this cycle.
REQ-005 o_sys_ready  output  1  register file accepts write-back this cycle.
REQ-006 i_wbu_gpr_wr_en  input  1  write request from write-back stage.
REQ-007 i_wbu_gpr_wr_id  input  GPRS_WIDTH  destination register index.
REQ-008 i_wbu_gpr_wr_data  input  DATA_WIDTH  write data.
REQ-009 i_idu_gpr_rd_id_1 / i_idu_gpr_rd_id_2  input  GPRS_WIDTH  read port 1/2 indices.
REQ-010 o_gpr_rd_data_1 / o_gpr_rd_data_2  output  DATA_WIDTH  read port 1/2 data, combinational.
REQ-011 i_idu_gpr_busy_set_en  input  1  decode issues an instruction writing a register.
REQ-012 i_idu_gpr_busy_set_id  input  GPRS_WIDTH  register marked pending.
REQ-013 o_gpr_rd_busy_1 / o_gpr_rd_busy_2  output  1  pending-write flag for read port 1/2 index.
REQ-014 i_gpr_flush  input  1  synchronous clear of all pending flags.

Function
REQ-015 Commit occurs when i_sys_valid && o_sys_ready && i_wbu_gpr_wr_en && i_wbu_gpr_wr_id != 0; the register is written at that rising edge.
REQ-016 Register 0 reads 0 always; writes, busy-sets and busy flags for index 0 are ignored (busy reads 0).
REQ-017 Read ports are combinational, both may address the same register, and neither stalls.
REQ-018 o_sys_ready is a register: 0 in reset, 1 from the first rising edge after i_rst_n deasserts, then held at 1.
REQ-019 Scoreboard: one busy bit per register, set at the edge where i_idu_gpr_busy_set_en is 1, cleared at the edge committing that index.
REQ-020 Simultaneous set and commit on the same index: set wins (bit stays 1).
REQ-021 i_gpr_flush clears all busy bits at the next edge, overriding same-cycle sets; register contents are unaffected and a same-cycle commit still writes.
REQ-022 Write with i_wbu_gpr_wr_en=0, or with i_sys_valid=0 or o_sys_ready=0, changes no state.
REQ-023 Setting an index that is already busy leaves it busy; no counter, no overflow.

Reset
REQ-024 While i_rst_n=0: all registers 0, all busy bits 0, o_sys_ready 0, all read data 0, all busy outputs 0.
REQ-025 Asserting reset mid-operation clears state immediately; a commit pending in that cycle is discarded.

Configuration
REQ-026 Macro GPR_BYPASS_EN: when defined, a read port whose index equals a committing nonzero index returns i_wbu_gpr_wr_data in the same cycle, and its busy output reads 0 unless the same index is also being set that cycle.
REQ-027 When GPR_BYPASS_EN is undefined, read ports return the stored value, and busy outputs the stored bit, until the edge after commit.

Verification
REQ-028 Reset, then read all 32 indices -> all 0; o_sys_ready 0 during reset and 1 one edge after release.
REQ-029 Commit x5=0xDEADBEEF, then read port 1 id 5 and port 2 id 5 -> both 0xDEADBEEF; commit x0=0x1234 -> x0 reads 0.
REQ-030 Same-cycle commit x7=0xA5A5A5A5 with rd_id_1=7 -> 0xA5A5A5A5 with GPR_BYPASS_EN, previous value without; next cycle 0xA5A5A5A5 in both builds.
REQ-031 Busy-set x3, then rd_id_1=3 -> busy 1; commit x3 -> busy 0 next cycle; set x3 and commit x3 in the same cycle -> busy stays 1.
REQ-032 Set busy on x1, x2, x31, then assert i_gpr_flush alongside a set of x4 -> all busy 0 next cycle; register values unchanged.
REQ-033 Commit x9=0x11 with i_rst_n asserted in the same cycle -> x9 reads 0 after reset release.

Source files
------------

// File: rtl/gpr_file_if.sv
// gpr_file_if: write-back, decode-scoreboard and read-port signals of the general-purpose register file.
`default_nettype none

interface gpr_file_if #(
  parameter int GPR_NUM    = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int GPRS_WIDTH = $clog2(GPR_NUM);

  logic                  i_sys_valid;
  logic                  o_sys_ready;
  logic                  i_wbu_gpr_wr_en;
  logic [GPRS_WIDTH-1:0] i_wbu_gpr_wr_id;
  logic [DATA_WIDTH-1:0] i_wbu_gpr_wr_data;
  logic [GPRS_WIDTH-1:0] i_idu_gpr_rd_id_1;
  logic [GPRS_WIDTH-1:0] i_idu_gpr_rd_id_2;
  logic [DATA_WIDTH-1:0] o_gpr_rd_data_1;
  logic [DATA_WIDTH-1:0] o_gpr_rd_data_2;
  logic                  i_idu_gpr_busy_set_en;
  logic [GPRS_WIDTH-1:0] i_idu_gpr_busy_set_id;
  logic                  o_gpr_rd_busy_1;
  logic                  o_gpr_rd_busy_2;
  logic                  i_gpr_flush;

  modport master (
    output i_sys_valid, i_wbu_gpr_wr_en, i_wbu_gpr_wr_id, i_wbu_gpr_wr_data,
    output i_idu_gpr_rd_id_1, i_idu_gpr_rd_id_2,
    output i_idu_gpr_busy_set_en, i_idu_gpr_busy_set_id, i_gpr_flush,
    input  o_sys_ready, o_gpr_rd_data_1, o_gpr_rd_data_2, o_gpr_rd_busy_1, o_gpr_rd_busy_2
  );

  modport slave (
    input  i_sys_valid, i_wbu_gpr_wr_en, i_wbu_gpr_wr_id, i_wbu_gpr_wr_data,
    input  i_idu_gpr_rd_id_1, i_idu_gpr_rd_id_2,
    input  i_idu_gpr_busy_set_en, i_idu_gpr_busy_set_id, i_gpr_flush,
    output o_sys_ready, o_gpr_rd_data_1, o_gpr_rd_data_2, o_gpr_rd_busy_1, o_gpr_rd_busy_2
  );
endinterface

`default_nettype wire

// File: rtl/gpr_file.sv
// gpr_file: GPR_NUM x DATA_WIDTH register file with two combinational read ports and a busy scoreboard.
// Optional macro GPR_BYPASS_EN forwards same-cycle commits to the read ports.
`default_nettype none

module gpr_file #(
  parameter int GPR_NUM    = 32,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic   i_clk,
  input  wire logic   i_rst_n,
  gpr_file_if.slave   bus
);
  localparam int GPRS_WIDTH = $clog2(GPR_NUM);

  logic [DATA_WIDTH-1:0]         regs [GPR_NUM];
  logic [GPR_NUM-1:0]            busy;
  logic [GPR_NUM-1:0]            busy_nxt;
  logic                          sys_ready;
  logic                          commit;
  logic [1:0][GPRS_WIDTH-1:0]    rd_id;
  logic [1:0][DATA_WIDTH-1:0]    rd_data;
  logic [1:0]                    rd_busy;

  assign commit = bus.i_sys_valid && sys_ready && bus.i_wbu_gpr_wr_en
                  && (bus.i_wbu_gpr_wr_id != '0);

  // Flush beats set, set beats commit-clear; index 0 never holds a pending flag.
  always_comb begin
    busy_nxt = busy;
    if (commit)
      busy_nxt[bus.i_wbu_gpr_wr_id] = 1'b0;
    if (bus.i_idu_gpr_busy_set_en)
      busy_nxt[bus.i_idu_gpr_busy_set_id] = 1'b1;
    if (bus.i_gpr_flush)
      busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sys_ready <= 1'b0;
      busy      <= '0;
      for (int i = 0; i < GPR_NUM; i++)
        regs[i] <= '0;
    end else begin
      sys_ready <= 1'b1;
      busy      <= busy_nxt;
      if (commit)
        regs[bus.i_wbu_gpr_wr_id] <= bus.i_wbu_gpr_wr_data;
    end
  end

  assign rd_id[0] = bus.i_idu_gpr_rd_id_1;
  assign rd_id[1] = bus.i_idu_gpr_rd_id_2;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = (rd_id[p] == '0) ? '0 : regs[rd_id[p]];
      rd_busy[p] = busy[rd_id[p]];
`ifdef GPR_BYPASS_EN
      if (commit && (bus.i_wbu_gpr_wr_id == rd_id[p])) begin
        rd_data[p] = bus.i_wbu_gpr_wr_data;
        if (!(bus.i_idu_gpr_busy_set_en && (bus.i_idu_gpr_busy_set_id == rd_id[p])))
          rd_busy[p] = 1'b0;
      end
`endif
    end
  end

  assign bus.o_sys_ready     = sys_ready;
  assign bus.o_gpr_rd_data_1 = rd_data[0];
  assign bus.o_gpr_rd_data_2 = rd_data[1];
  assign bus.o_gpr_rd_busy_1 = rd_busy[0];
  assign bus.o_gpr_rd_busy_2 = rd_busy[1];

endmodule

`default_nettype wire

// File: tb/tb_gpr_file.sv
// tb_gpr_file: directed scenarios plus randomized traffic checked every cycle against a behavioural model.
`default_nettype none

module tb_gpr_file;
  logic clk = 1'b0;
  logic rst_n;
  logic chk_en = 1'b0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  gpr_file_if #(.GPR_NUM(32), .DATA_WIDTH(32)) bus ();

  gpr_file #(.GPR_NUM(32), .DATA_WIDTH(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Behavioural model: plain arrays updated by the rules, once per rising edge.
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_ready;

  function automatic bit commit_now();
    return rst_n && bus.i_sys_valid && m_ready && bus.i_wbu_gpr_wr_en
           && (bus.i_wbu_gpr_wr_id != 5'd0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'd0;
        m_busy[i] = 1'b0;
      end
      m_ready = 1'b0;
    end else begin
      if (commit_now()) begin
        m_regs[bus.i_wbu_gpr_wr_id] = bus.i_wbu_gpr_wr_data;
        m_busy[bus.i_wbu_gpr_wr_id] = 1'b0;
      end
      if (bus.i_idu_gpr_busy_set_en && bus.i_idu_gpr_busy_set_id != 5'd0)
        m_busy[bus.i_idu_gpr_busy_set_id] = 1'b1;
      if (bus.i_gpr_flush)
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_ready = 1'b1;
    end
  end

  function automatic logic [31:0] exp_data(input logic [4:0] id);
    if (id == 5'd0) return 32'd0;
`ifdef GPR_BYPASS_EN
    if (commit_now() && bus.i_wbu_gpr_wr_id == id) return bus.i_wbu_gpr_wr_data;
`endif
    return m_regs[id];
  endfunction

  function automatic logic exp_busy(input logic [4:0] id);
    if (id == 5'd0) return 1'b0;
`ifdef GPR_BYPASS_EN
    if (commit_now() && bus.i_wbu_gpr_wr_id == id
        && !(bus.i_idu_gpr_busy_set_en && bus.i_idu_gpr_busy_set_id == id))
      return 1'b0;
`endif
    return m_busy[id];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_rd_data_1", bus.o_gpr_rd_data_1, exp_data(bus.i_idu_gpr_rd_id_1));
      chk("model_rd_data_2", bus.o_gpr_rd_data_2, exp_data(bus.i_idu_gpr_rd_id_2));
      chk("model_rd_busy_1", {31'd0, bus.o_gpr_rd_busy_1}, {31'd0, exp_busy(bus.i_idu_gpr_rd_id_1)});
      chk("model_rd_busy_2", {31'd0, bus.o_gpr_rd_busy_2}, {31'd0, exp_busy(bus.i_idu_gpr_rd_id_2)});
      chk("model_sys_ready", {31'd0, bus.o_sys_ready}, {31'd0, rst_n ? m_ready : 1'b0});
    end
  end

  task automatic idle();
    bus.i_sys_valid           = 1'b0;
    bus.i_wbu_gpr_wr_en       = 1'b0;
    bus.i_wbu_gpr_wr_id       = 5'd0;
    bus.i_wbu_gpr_wr_data     = 32'd0;
    bus.i_idu_gpr_busy_set_en = 1'b0;
    bus.i_idu_gpr_busy_set_id = 5'd0;
    bus.i_gpr_flush           = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] id, input logic [31:0] data);
    bus.i_sys_valid       = 1'b1;
    bus.i_wbu_gpr_wr_en   = 1'b1;
    bus.i_wbu_gpr_wr_id   = id;
    bus.i_wbu_gpr_wr_data = data;
  endtask

  task automatic set_busy(input logic [4:0] id);
    bus.i_idu_gpr_busy_set_en = 1'b1;
    bus.i_idu_gpr_busy_set_id = id;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    bus.i_idu_gpr_rd_id_1 = 5'd0;
    bus.i_idu_gpr_rd_id_2 = 5'd0;
    #2;
    chk_en = 1'b1;

    // Reset: every index reads 0, not ready.
    for (int i = 0; i < 32; i++) begin
      bus.i_idu_gpr_rd_id_1 = 5'(i);
      bus.i_idu_gpr_rd_id_2 = 5'(31 - i);
      #1;
      chk("reset_rd_1", bus.o_gpr_rd_data_1, 32'd0);
      chk("reset_rd_2", bus.o_gpr_rd_data_2, 32'd0);
    end
    chk("reset_ready", {31'd0, bus.o_sys_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", {31'd0, bus.o_sys_ready}, 32'd0);
    tick();
    chk("ready_after_edge", {31'd0, bus.o_sys_ready}, 32'd1);

    // Basic commit and x0 immunity.
    wr(5'd5, 32'hDEADBEEF);
    tick(); idle();
    bus.i_idu_gpr_rd_id_1 = 5'd5;
    bus.i_idu_gpr_rd_id_2 = 5'd5;
    #1;
    chk("x5_port1", bus.o_gpr_rd_data_1, 32'hDEADBEEF);
    chk("x5_port2", bus.o_gpr_rd_data_2, 32'hDEADBEEF);
    wr(5'd0, 32'h1234);
    tick(); idle();
    bus.i_idu_gpr_rd_id_1 = 5'd0;
    #1;
    chk("x0_reads_zero", bus.o_gpr_rd_data_1, 32'd0);

    // Same-cycle commit visibility.
    wr(5'd7, 32'h0000_0001);
    tick();
    wr(5'd7, 32'hA5A5A5A5);
    bus.i_idu_gpr_rd_id_1 = 5'd7;
    #1;
`ifdef GPR_BYPASS_EN
    chk("x7_same_cycle", bus.o_gpr_rd_data_1, 32'hA5A5A5A5);
`else
    chk("x7_same_cycle", bus.o_gpr_rd_data_1, 32'h0000_0001);
`endif
    tick(); idle();
    #1;
    chk("x7_next_cycle", bus.o_gpr_rd_data_1, 32'hA5A5A5A5);

    // Scoreboard set / clear / set-wins.
    set_busy(5'd3);
    tick(); idle();
    bus.i_idu_gpr_rd_id_1 = 5'd3;
    #1;
    chk("x3_busy_set", {31'd0, bus.o_gpr_rd_busy_1}, 32'd1);
    wr(5'd3, 32'h33);
    tick(); idle();
    #1;
    chk("x3_busy_cleared", {31'd0, bus.o_gpr_rd_busy_1}, 32'd0);
    wr(5'd3, 32'h34);
    set_busy(5'd3);
    tick(); idle();
    #1;
    chk("x3_set_wins", {31'd0, bus.o_gpr_rd_busy_1}, 32'd1);

    // Flush overrides a same-cycle set; data untouched.
    set_busy(5'd1);  tick();
    set_busy(5'd2);  tick();
    set_busy(5'd31); tick();
    set_busy(5'd4);
    bus.i_gpr_flush = 1'b1;
    tick(); idle();
    bus.i_idu_gpr_rd_id_1 = 5'd1;
    bus.i_idu_gpr_rd_id_2 = 5'd2;
    #1;
    chk("flush_x1", {31'd0, bus.o_gpr_rd_busy_1}, 32'd0);
    chk("flush_x2", {31'd0, bus.o_gpr_rd_busy_2}, 32'd0);
    bus.i_idu_gpr_rd_id_1 = 5'd31;
    bus.i_idu_gpr_rd_id_2 = 5'd4;
    #1;
    chk("flush_x31", {31'd0, bus.o_gpr_rd_busy_1}, 32'd0);
    chk("flush_x4", {31'd0, bus.o_gpr_rd_busy_2}, 32'd0);
    bus.i_idu_gpr_rd_id_1 = 5'd5;
    bus.i_idu_gpr_rd_id_2 = 5'd7;
    #1;
    chk("flush_keeps_x5", bus.o_gpr_rd_data_1, 32'hDEADBEEF);
    chk("flush_keeps_x7", bus.o_gpr_rd_data_2, 32'hA5A5A5A5);

    // Commit coincident with reset is discarded.
    wr(5'd9, 32'h11);
    rst_n = 1'b0;
    #1;
    chk("reset_clears_x5", bus.o_gpr_rd_data_1, 32'd0);
    tick(); idle();
    rst_n = 1'b1;
    tick();
    bus.i_idu_gpr_rd_id_1 = 5'd9;
    #1;
    chk("x9_discarded", bus.o_gpr_rd_data_1, 32'd0);

    // Randomized traffic, checked every cycle by the compare process.
    for (int n = 0; n < 2000; n++) begin
      bus.i_sys_valid           = ($urandom_range(0, 3) != 0);
      bus.i_wbu_gpr_wr_en       = ($urandom_range(0, 3) != 0);
      bus.i_wbu_gpr_wr_id       = 5'($urandom_range(0, 31));
      bus.i_wbu_gpr_wr_data     = $urandom;
      bus.i_idu_gpr_busy_set_en = $urandom_range(0, 1) == 1;
      bus.i_idu_gpr_busy_set_id = ($urandom_range(0, 3) == 0) ? bus.i_wbu_gpr_wr_id
                                                              : 5'($urandom_range(0, 31));
      bus.i_gpr_flush           = ($urandom_range(0, 19) == 0);
      bus.i_idu_gpr_rd_id_1     = ($urandom_range(0, 2) == 0) ? bus.i_wbu_gpr_wr_id
                                                              : 5'($urandom_range(0, 31));
      bus.i_idu_gpr_rd_id_2     = 5'($urandom_range(0, 31));
      rst_n                     = ($urandom_range(0, 299) != 0);
      tick();
    end
    idle();
    rst_n = 1'b1;
    tick();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
